// File: rtl/key_vault_pkg.sv
// Shared types and helpers for the key vault: zeroize FSM states and lane count.
package key_vault_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WIPE = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int lanes(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/key_lane_parity.sv
// Combinational per-byte-lane parity: par_o[i] is the XOR of key_i[8i+:8].
module key_lane_parity
  import key_vault_pkg::*;
#(
  parameter int W = 128
) (
  input  logic [W-1:0]        key_i,
  output logic [lanes(W)-1:0] par_o
);

  always_comb begin
    par_o = '0;
    for (int i = 0; i < lanes(W); i++) begin
      par_o[i] = ^key_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/key_vault_zeroize.sv
// Multi-slot key store with per-slot write lock, lane parity, tamper latch and
// an FSM that wipes one slot per cycle, then pulses zeroize_done.
// Handshake: rd_en is sampled on clk and answered by a one-cycle rd_valid pulse
// on the next cycle; wr_en is sampled on clk and a rejection shows as a
// one-cycle wr_err pulse on the next cycle. There is no back-pressure.
module key_vault_zeroize
  import key_vault_pkg::*;
#(
  parameter int W = 128,
  parameter int N = 4,
  localparam int SW = $clog2(N),
  localparam int L = lanes(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_slot,
  input  logic [W-1:0]  wr_key,
  input  logic          wr_lock,
  output logic          wr_err,
  input  logic          rd_en,
  input  logic [SW-1:0] rd_slot,
  output logic          rd_valid,
  output logic [W-1:0]  rd_key,
  output logic          rd_err,
  input  logic          soft_zeroize,
  input  logic          tamper,
  output logic          tamper_seen,
  output logic          busy,
  output logic          zeroize_done,
  output logic [1:0]    dbg_state
);

  localparam logic [SW:0]   N_EXT    = (SW+1)'(N);
  localparam logic [SW-1:0] IDX_LAST = SW'(N - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] idx_q, idx_d;
  logic          wipe_en;

  logic [W-1:0]  key_q [N];
  logic [L-1:0]  par_q [N];
  logic [N-1:0]  lock_q;

  logic          tamper_s1_q, tamper_s2_q, tamper_seen_q;
  logic          wr_err_q, rd_valid_q, rd_err_q;
  logic [W-1:0]  rd_key_q;

  logic          zreq, wr_accept, wr_slot_ok, rd_slot_ok;
  logic [L-1:0]  wr_par, rd_calc_par;
  logic [W-1:0]  rd_sel_key;

  assign zreq       = soft_zeroize | tamper_s2_q;
  assign wr_slot_ok = ({1'b0, wr_slot} < N_EXT);
  assign rd_slot_ok = ({1'b0, rd_slot} < N_EXT);
  assign wr_accept  = wr_en && (state_q == IDLE) && !zreq && !tamper_seen_q &&
                      wr_slot_ok && !lock_q[wr_slot];
  assign rd_sel_key = key_q[rd_slot];

  key_lane_parity #(.W(W)) u_wr_parity (.key_i(wr_key),     .par_o(wr_par));
  key_lane_parity #(.W(W)) u_rd_parity (.key_i(rd_sel_key), .par_o(rd_calc_par));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wipe_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (zreq) begin
          state_d = WIPE;
          idx_d   = '0;
        end
      end
      WIPE: begin
        wipe_en = 1'b1;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Wipe and write are exclusive: a write is only accepted while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        key_q[i] <= '0;
        par_q[i] <= '0;
      end
      lock_q <= '0;
    end else if (wipe_en) begin
      key_q[idx_q]  <= '0;
      par_q[idx_q]  <= '0;
      lock_q[idx_q] <= 1'b0;
    end else if (wr_accept) begin
      key_q[wr_slot] <= wr_key;
      par_q[wr_slot] <= wr_par;
      if (wr_lock) lock_q[wr_slot] <= 1'b1;
    end
  end

  // The sticky flag taps the first sync stage so it rises with the second one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tamper_s1_q   <= 1'b0;
      tamper_s2_q   <= 1'b0;
      tamper_seen_q <= 1'b0;
    end else begin
      tamper_s1_q   <= tamper;
      tamper_s2_q   <= tamper_s1_q;
      tamper_seen_q <= tamper_seen_q | tamper_s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_err_q   <= wr_en && !wr_accept;
      rd_valid_q <= rd_en;
      if (!rd_en) begin
        rd_key_q <= '0;
        rd_err_q <= 1'b0;
      end else if (!rd_slot_ok) begin
        rd_key_q <= '0;
        rd_err_q <= 1'b1;
      end else if ((state_q != IDLE) || tamper_seen_q) begin
        rd_key_q <= '0;
        rd_err_q <= 1'b0;
      end else begin
        rd_key_q <= rd_sel_key;
        rd_err_q <= (rd_calc_par != par_q[rd_slot]);
      end
    end
  end

  assign wr_err       = wr_err_q;
  assign rd_valid     = rd_valid_q;
  assign rd_key       = rd_key_q;
  assign rd_err       = rd_err_q;
  assign tamper_seen  = tamper_seen_q;
  assign busy         = (state_q != IDLE);
  assign zeroize_done = (state_q == DONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_key_vault_zeroize.sv
// Bench for key_vault_zeroize: vector table, directed corner sequences and
// random traffic checked against a cycle-level behavioural model.
module tb_key_vault_zeroize;

  localparam int W  = 128;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int L  = W / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [SW-1:0] wr_slot = '0;
  logic [W-1:0]  wr_key = '0;
  logic          wr_lock = 1'b0;
  logic          wr_err;
  logic          rd_en = 1'b0;
  logic [SW-1:0] rd_slot = '0;
  logic          rd_valid;
  logic [W-1:0]  rd_key;
  logic          rd_err;
  logic          soft_zeroize = 1'b0;
  logic          tamper = 1'b0;
  logic          tamper_seen;
  logic          busy;
  logic          zeroize_done;
  logic [1:0]    dbg_state;

  key_vault_zeroize #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_key(wr_key), .wr_lock(wr_lock), .wr_err(wr_err),
    .rd_en(rd_en), .rd_slot(rd_slot), .rd_valid(rd_valid), .rd_key(rd_key), .rd_err(rd_err),
    .soft_zeroize(soft_zeroize), .tamper(tamper), .tamper_seen(tamper_seen),
    .busy(busy), .zeroize_done(zeroize_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // m_cyc counts cycles since a wipe began: 0 = idle, 1..N wiping slot m_cyc-1,
  // N+1 = the done cycle.
  int           m_cyc;
  logic [W-1:0] m_key [N];
  logic [L-1:0] m_par [N];
  bit           m_lock [N];
  bit           m_s1, m_s2, m_seen;
  bit           exp_valid, exp_err, exp_wr_err;
  logic [W-1:0] exp_q [$];

  function automatic logic [L-1:0] lane_par(input logic [W-1:0] k);
    logic [L-1:0] p;
    for (int i = 0; i < L; i++) p[i] = ^k[8*i +: 8];
    return p;
  endfunction

  task automatic model_reset();
    m_cyc = 0;
    for (int i = 0; i < N; i++) begin
      m_key[i] = '0; m_par[i] = '0; m_lock[i] = 0;
    end
    m_s1 = 0; m_s2 = 0; m_seen = 0;
    exp_valid = 0; exp_err = 0; exp_wr_err = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit idle, zreq, accept;
    idle   = (m_cyc == 0);
    zreq   = soft_zeroize || m_s2;
    accept = wr_en && idle && !zreq && !m_seen && !m_lock[wr_slot];
    exp_wr_err = wr_en && !accept;
    exp_valid  = rd_en;
    if (!rd_en || !idle || m_seen) begin
      exp_q.push_back('0);
      exp_err = 0;
    end else begin
      exp_q.push_back(m_key[rd_slot]);
      exp_err = (lane_par(m_key[rd_slot]) != m_par[rd_slot]);
    end
    if (m_cyc >= 1 && m_cyc <= N) begin
      m_key[m_cyc-1] = '0; m_par[m_cyc-1] = '0; m_lock[m_cyc-1] = 0;
    end else if (accept) begin
      m_key[wr_slot] = wr_key;
      m_par[wr_slot] = lane_par(wr_key);
      if (wr_lock) m_lock[wr_slot] = 1;
    end
    if (m_cyc == 0)          m_cyc = zreq ? 1 : 0;
    else if (m_cyc == N + 1) m_cyc = 0;
    else                     m_cyc++;
    m_seen = m_seen || m_s1;
    m_s2   = m_s1;
    m_s1   = tamper;
  endtask

  task automatic check_model();
    logic [W-1:0] ek;
    ek = '0;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      ek = exp_q.pop_front();
    end
    chk("m_rd_valid", rd_valid, exp_valid);
    chk("m_rd_key", rd_key, ek);
    chk("m_rd_err", rd_err, exp_err);
    chk("m_wr_err", wr_err, exp_wr_err);
    chk("m_busy", busy, (m_cyc != 0));
    chk("m_zeroize_done", zeroize_done, (m_cyc == N + 1));
    chk("m_tamper_seen", tamper_seen, m_seen);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_lock = 0; rd_en = 0; soft_zeroize = 0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    tamper = 0;
    rst_n  = 0;
    #1;
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_key"}, rd_key, 0);
    chk({tag, "_rd_err"}, rd_err, 0);
    chk({tag, "_wr_err"}, wr_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_zeroize_done"}, zeroize_done, 0);
    chk({tag, "_tamper_seen"}, tamper_seen, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic read_slot(input int s, output logic [W-1:0] k, output logic e);
    rd_en = 1; rd_slot = SW'(s);
    tick();
    rd_en = 0;
    k = rd_key; e = rd_err;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wr_en;
    logic [SW-1:0] wr_slot;
    logic [W-1:0]  wr_key;
    logic          wr_lock;
    logic          rd_en;
    logic [SW-1:0] rd_slot;
    logic          e_wr_err;
    logic          e_rd_valid;
    logic [W-1:0]  e_rd_key;
    logic          e_rd_err;
  } vec_t;

  function automatic vec_t mk(input logic we, input int ws, input logic [W-1:0] wk,
                              input logic wl, input logic re, input int rs,
                              input logic ewe, input logic erv, input logic [W-1:0] erk,
                              input logic ere);
    vec_t v;
    v.wr_en = we; v.wr_slot = SW'(ws); v.wr_key = wk; v.wr_lock = wl;
    v.rd_en = re; v.rd_slot = SW'(rs);
    v.e_wr_err = ewe; v.e_rd_valid = erv; v.e_rd_key = erk; v.e_rd_err = ere;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    logic [W-1:0] a5, k1234, kff, kflip, k, k0, k3;
    logic         e;
    int           busy_cnt, done_at, done_cnt;

    a5    = {16{8'hA5}};
    k1234 = W'(16'h1234);
    kff   = W'(8'hFF);
    k0    = {4{32'hDEADBEEF}};
    k3    = {4{32'h0BADF00D}};

    vecs[0]  = mk(0, 0, '0,    0, 1, 0, 0, 1, '0,    0);
    vecs[1]  = mk(0, 0, '0,    0, 1, 1, 0, 1, '0,    0);
    vecs[2]  = mk(0, 0, '0,    0, 1, 2, 0, 1, '0,    0);
    vecs[3]  = mk(0, 0, '0,    0, 1, 3, 0, 1, '0,    0);
    vecs[4]  = mk(1, 1, a5,    1, 0, 0, 0, 0, '0,    0);
    vecs[5]  = mk(1, 1, k1234, 0, 1, 1, 1, 1, a5,    0);
    vecs[6]  = mk(0, 0, '0,    0, 1, 1, 0, 1, a5,    0);
    vecs[7]  = mk(1, 3, k1234, 0, 1, 3, 0, 1, '0,    0);
    vecs[8]  = mk(0, 0, '0,    0, 1, 3, 0, 1, k1234, 0);
    vecs[9]  = mk(1, 3, kff,   0, 0, 0, 0, 0, '0,    0);
    vecs[10] = mk(0, 0, '0,    0, 1, 3, 0, 1, kff,   0);

    do_reset("reset");

    // Reset reads, lock rejection, same-cycle read-before-write.
    for (int v = 0; v < NV; v++) begin
      wr_en = vecs[v].wr_en; wr_slot = vecs[v].wr_slot; wr_key = vecs[v].wr_key;
      wr_lock = vecs[v].wr_lock; rd_en = vecs[v].rd_en; rd_slot = vecs[v].rd_slot;
      tick();
      chk($sformatf("vec%0d_wr_err", v), wr_err, vecs[v].e_wr_err);
      chk($sformatf("vec%0d_rd_valid", v), rd_valid, vecs[v].e_rd_valid);
      chk($sformatf("vec%0d_rd_key", v), rd_key, vecs[v].e_rd_key);
      chk($sformatf("vec%0d_rd_err", v), rd_err, vecs[v].e_rd_err);
    end
    idle_inputs();
    chk("vec_busy_idle", busy, 0);

    // One-cycle soft zeroize: N+1 busy cycles, done in the last one.
    busy_cnt = 0; done_at = 0;
    soft_zeroize = 1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      soft_zeroize = 0;
      if (busy) busy_cnt++;
      if (zeroize_done) done_at = j;
    end
    chk("soft_busy_cycles", busy_cnt, N + 1);
    chk("soft_done_cycle", done_at, N + 1);
    for (int s = 0; s < N; s++) begin
      read_slot(s, k, e);
      chk($sformatf("soft_wiped_slot%0d", s), k, '0);
    end
    wr_en = 1; wr_slot = 1; wr_key = W'(8'h55); wr_lock = 0;
    tick();
    idle_inputs();
    chk("soft_unlocked_wr_err", wr_err, 0);
    read_slot(1, k, e);
    chk("soft_rewrite_slot1", k, W'(8'h55));

    // Corrupt one stored bit and expect a parity error on read.
    wr_en = 1; wr_slot = 2; wr_key = {W{1'b1}};
    tick();
    idle_inputs();
    dut.key_q[2][3] <= ~dut.key_q[2][3];
    m_key[2][3] = ~m_key[2][3];
    kflip = {W{1'b1}};
    kflip[3] = 1'b0;
    read_slot(2, k, e);
    chk("parity_rd_err", e, 1);
    chk("parity_rd_key", k, kflip);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_slot = SW'($urandom_range(0, N - 1));
      wr_key = {$urandom, $urandom, $urandom, $urandom};
      wr_lock = ($urandom_range(0, 3) == 0);
      rd_en = $urandom_range(0, 1) == 1;
      rd_slot = SW'($urandom_range(0, N - 1));
      soft_zeroize = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle_inputs();
    repeat (N + 2) tick();

    // Asynchronous tamper: flag after two clocks, one wipe, then lockout.
    wr_en = 1; wr_slot = 0; wr_key = k0;
    tick();
    idle_inputs();
    #2 tamper = 1;
    tick();
    chk("tamper_seen_early", tamper_seen, 0);
    tick();
    chk("tamper_seen_2clk", tamper_seen, 1);
    tamper = 0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (zeroize_done) done_cnt++;
    end
    chk("tamper_wipe_done_cnt", done_cnt, 1);
    chk("tamper_wipe_finished", busy, 0);
    wr_en = 1; wr_slot = 0; wr_key = k3;
    tick();
    idle_inputs();
    chk("tamper_wr_err", wr_err, 1);
    read_slot(0, k, e);
    chk("tamper_rd_key", k, '0);
    chk("tamper_rd_err", e, 0);
    chk("tamper_still_seen", tamper_seen, 1);

    // Write loses to zeroize; reset mid-wipe clears all with no done pulse.
    do_reset("reset2");
    wr_en = 1; wr_slot = 0; wr_key = k0;
    tick();
    wr_slot = 3; wr_key = k3;
    tick();
    wr_slot = 1; wr_key = k1234; soft_zeroize = 1;
    tick();
    idle_inputs();
    chk("zwr_wr_err", wr_err, 1);
    repeat (2) tick();
    chk("zwr_busy_mid_wipe", busy, 1);
    do_reset("reset_mid_wipe");
    done_cnt = 0;
    for (int s = 0; s < 8; s++) begin
      read_slot(s % N, k, e);
      if (zeroize_done) done_cnt++;
      chk($sformatf("post_reset_slot%0d", s % N), k, '0);
    end
    chk("post_reset_no_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
